// File: rtl/conv_bias_add_pkg.sv
// Shared types and defaults for the conv bias-add stage.
package conv_bias_add_pkg;

  // Frame phase: load the per-frame biases, then stream the accumulators.
  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int KERN_NUM_DEF   = 16;
  localparam int PIXELS_DEF     = 64;
  localparam int COEFF_W_DEF    = 16;
  localparam int ACC_W_DEF      = 32;
  localparam int BIAS_SHIFT_DEF = 8;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_bias_add_if.sv
// FIFO-style stream bundle: bias in, accumulator in, result out.
// master = the surrounding FIFOs, slave = the bias-add block.
interface conv_bias_add_if
  import conv_bias_add_pkg::*;
#(
  parameter int COEFF_W = COEFF_W_DEF,
  parameter int ACC_W   = ACC_W_DEF
);
  logic [COEFF_W-1:0] bias_V_dout;
  logic               bias_V_empty_n;
  logic               bias_V_read;
  logic [ACC_W-1:0]   acc_V_dout;
  logic               acc_V_empty_n;
  logic               acc_V_read;
  logic [ACC_W-1:0]   output_V_din;
  logic               output_V_full_n;
  logic               output_V_write;

  modport master (
    output bias_V_dout, bias_V_empty_n, input bias_V_read,
    output acc_V_dout, acc_V_empty_n, input acc_V_read,
    input output_V_din, output output_V_full_n, input output_V_write
  );

  modport slave (
    input bias_V_dout, bias_V_empty_n, output bias_V_read,
    input acc_V_dout, acc_V_empty_n, output acc_V_read,
    output output_V_din, input output_V_full_n, output output_V_write
  );
endinterface

// File: rtl/conv_bias_add_sat_add.sv
// Sign-extend and align a bias, add it to an accumulator, saturate.
module conv_bias_add_sat_add #(
  parameter int COEFF_W    = 16,
  parameter int ACC_W      = 32,
  parameter int BIAS_SHIFT = 8
) (
  input  logic [ACC_W-1:0]   acc,
  input  logic [COEFF_W-1:0] bias,
  output logic [ACC_W-1:0]   sum
);
  logic [ACC_W:0] acc_x;
  logic [ACC_W:0] bias_x;
  logic [ACC_W:0] sum_x;

  // One guard bit above ACC_W exposes overflow as a top-two-bit mismatch.
  always_comb begin
    acc_x  = {acc[ACC_W-1], acc};
    bias_x = {{(ACC_W+1-COEFF_W){bias[COEFF_W-1]}}, bias} << BIAS_SHIFT;
    sum_x  = acc_x + bias_x;
    if (sum_x[ACC_W] != sum_x[ACC_W-1])
      sum = sum_x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sum = sum_x[ACC_W-1:0];
  end
endmodule

// File: rtl/conv_bias_add.sv
// Per-frame bias load followed by channel-interleaved bias add with
// saturation; one-entry output register with full throughput.
module conv_bias_add
  import conv_bias_add_pkg::*;
#(
  parameter int KERN_NUM   = KERN_NUM_DEF,
  parameter int PIXELS     = PIXELS_DEF,
  parameter int COEFF_W    = COEFF_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int BIAS_SHIFT = BIAS_SHIFT_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  conv_bias_add_if.slave    sif,
  output logic              frame_done
);
  localparam int CH_W  = cnt_w(KERN_NUM);
  localparam int PIX_W = cnt_w(PIXELS);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(KERN_NUM - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);

  state_t             state;
  logic               alive;      // low for the first cycle after reset release
  logic [CH_W-1:0]    ch_cnt;
  logic [PIX_W-1:0]   pix_cnt;
  logic               out_valid;
  logic               out_last;   // out_reg holds the final result of a frame
  logic [ACC_W-1:0]   out_reg;
  logic [ACC_W-1:0]   sum;
  logic [COEFF_W-1:0] bias_rf [KERN_NUM];

  logic bias_rd, acc_rd, wr, adv, last_ch, last_pix;

  conv_bias_add_sat_add #(
    .COEFF_W(COEFF_W), .ACC_W(ACC_W), .BIAS_SHIFT(BIAS_SHIFT)
  ) u_sat_add (
    .acc  (sif.acc_V_dout),
    .bias (bias_rf[ch_cnt]),
    .sum  (sum)
  );

  // Handshake strobes; all held low while in (or just out of) reset.
  always_comb begin
    last_ch  = (ch_cnt == CH_LAST);
    last_pix = (pix_cnt == PIX_LAST);
    adv      = !out_valid || sif.output_V_full_n;
    bias_rd  = alive && (state == LOAD) && sif.bias_V_empty_n;
    acc_rd   = alive && (state == RUN) && sif.acc_V_empty_n && adv;
    wr       = out_valid && sif.output_V_full_n;
  end

  assign sif.bias_V_read    = bias_rd;
  assign sif.acc_V_read     = acc_rd;
  assign sif.output_V_write = wr;
  assign sif.output_V_din   = out_reg;
  assign frame_done         = wr && out_last;

  // Bias register file: not reset, rewritten by every frame's load burst.
  always_ff @(posedge ap_clk) begin
    if (bias_rd) bias_rf[ch_cnt] <= sif.bias_V_dout;
  end

  // Frame sequencing and the output register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= LOAD;
      alive     <= 1'b0;
      ch_cnt    <= '0;
      pix_cnt   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_reg   <= '0;
    end else begin
      alive <= 1'b1;
      if (bias_rd) begin
        if (last_ch) begin
          ch_cnt <= '0;
          state  <= RUN;
        end else begin
          ch_cnt <= ch_cnt + 1'b1;
        end
      end
      if (acc_rd) begin
        out_reg   <= sum;
        out_valid <= 1'b1;
        out_last  <= last_ch && last_pix;
        if (last_ch) begin
          ch_cnt <= '0;
          if (last_pix) begin
            pix_cnt <= '0;
            state   <= LOAD;
          end else begin
            pix_cnt <= pix_cnt + 1'b1;
          end
        end else begin
          ch_cnt <= ch_cnt + 1'b1;
        end
      end else if (wr) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: doc/conv_bias_add.md
Name: conv_bias_add

Overview:
- Stage directly downstream of the per-layer bias streamer.
- Once per frame, consumes the KERN_NUM bias coefficients from the bias stream into a local register file.
- Then consumes the convolution accumulator stream (channel-interleaved, channel 0 first per pixel) and adds the aligned, sign-extended bias of the matching channel.
- Emits the saturated sum on an output stream toward the activation/requant stage; all streams use the FIFO-style dout/empty_n/read and din/full_n/write handshake.

Parameters:
- KERN_NUM, 16, output channels (bias entries per frame); must be >= 1.
- PIXELS, 64, output pixels per frame; must be >= 1.
- COEFF_W, 16, bias width, signed.
- ACC_W, 32, accumulator and output width, signed.
- BIAS_SHIFT, 8, left shift aligning bias to the accumulator fixed-point position; COEFF_W+BIAS_SHIFT <= ACC_W.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- bias_V_dout  in  COEFF_W  bias coefficient from the bias streamer FIFO.
- bias_V_empty_n  in  1  bias FIFO non-empty.
- bias_V_read  out  1  pops the bias FIFO.
- acc_V_dout  in  ACC_W  accumulator value.
- acc_V_empty_n  in  1  accumulator FIFO non-empty.
- acc_V_read  out  1  pops the accumulator FIFO.
- output_V_din  out  ACC_W  biased, saturated result.
- output_V_full_n  in  1  downstream FIFO has space.
- output_V_write  out  1  pushes output_V_din.
- frame_done  out  1  one-cycle pulse when the last result of a frame is written.

Behaviour:
- Reset (async assert, sync release): state=LOAD, ch_cnt=0, pix_cnt=0, out_valid=0, all read/write strobes 0, frame_done=0, output_V_din=0. The bias register file is not cleared and is treated as invalid.
- LOAD state:
  - bias_V_read = bias_V_empty_n; on each read, bias_rf[ch_cnt] <= bias_V_dout and ch_cnt increments.
  - acc_V_read = 0 throughout.
  - On reading entry KERN_NUM-1: ch_cnt <= 0, state <= RUN.
- RUN state:
  - bias_V_read = 0.
  - adv = !out_valid | output_V_full_n.
  - acc_V_read = acc_V_empty_n & adv.
  - On a read: out_reg <= sat(acc_V_dout + (sext(bias_rf[ch_cnt]) << BIAS_SHIFT)), out_valid <= 1.
  - ch_cnt wraps at KERN_NUM-1, which increments pix_cnt.
  - On the read of the last channel of pixel PIXELS-1: both counters clear and state <= LOAD.
- Arithmetic:
  - Sum computed in ACC_W+1 bits.
  - If sum > 2^(ACC_W-1)-1, clamp to max; if sum < -2^(ACC_W-1), clamp to min.
  - No rounding.
- Output stage:
  - output_V_write = out_valid & output_V_full_n; output_V_din = out_reg.
  - out_valid clears on a write unless a new read refills it in the same cycle.
  - Throughput 1 result/cycle; latency 1 cycle from acc read to write eligibility.
  - While output_V_full_n=0, out_reg is held stable and no acc read occurs once out_valid=1.
- frame_done asserts in the cycle the last result of a frame is written, i.e. output_V_write=1 for the result taken from the final RUN read.
- Frame overlap: after the final RUN read the block is in LOAD and may load next-frame biases while the last result is still pending. out_reg is already computed and is unaffected.
- Bias starvation in LOAD: the block waits indefinitely and never touches the acc stream.
- Acc starvation in RUN: the block waits; counters hold.
- Reset mid-frame: all partial progress is discarded, any pending out_reg result is dropped, and the next frame requires a fresh bias burst.

Decomposition:
- Shared package/header `layers_sizes.vh` / `my_types.vh`:
  - per-layer KERN_NUM and PIXELS constants;
  - coeff_width and acc_width;
  - a state encoding constant pair LOAD/RUN.
- One natural sub-module: sat_add, the combinational sign-extend/shift/add/saturate function, reusable by the other requant stages.

Test Plan (KERN_NUM=4, PIXELS=2, COEFF_W=8, ACC_W=16, BIAS_SHIFT=4):
- Basic: biases {1,-2,3,0} then accs {0x0010,0x0000,0x0100,0x1234} -> outputs 0x0020, 0xFFE0, 0x0130, 0x1234 in order.
- Saturation: bias ch0=0x7F with acc 0x7FF0 -> 0x7FFF; bias ch1=-2 with acc 0x8010 -> 0x8000.
- Backpressure: output_V_full_n low for 5 cycles mid-pixel -> output_V_din stable, acc_V_read=0 after first stall, all 8 results delivered in order with none duplicated.
- Bias starvation: only 2 biases available, acc FIFO full -> acc_V_read stays 0 until the remaining 2 biases arrive; the first output then uses the correct bias.
- Frame rollover: after 8 results, exactly one frame_done pulse; a second burst {5,5,5,5} is consumed before any further acc read, and second-frame acc 0 yields output 0x0050.
- Reset mid-frame: assert ap_rst_n=0 after 3 results -> strobes drop immediately; after release the block demands 4 new biases before reading acc.
